// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, requester indices and default widths
// for the mem_arbiter slice (arbiter top, winner-select sub-module, bench).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Requester indices: 0 is instruction fetch, 1 is data load/store.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes plus the unidirectional memory
// control pins. The bidirectional data bus stays a plain inout port on the
// arbiter so bus turnaround is resolved at the module boundary.
interface mem_arbiter_if #(
    parameter int addr_width = 5,
    parameter int data_width = 8
);

    // Requester 0 (instruction fetch)
    logic                  req0;
    logic                  we0;
    logic [addr_width-1:0] addr0;
    logic [data_width-1:0] wdata0;
    logic                  ack0;
    logic [data_width-1:0] rdata0;

    // Requester 1 (data load/store)
    logic                  req1;
    logic                  we1;
    logic [addr_width-1:0] addr1;
    logic [data_width-1:0] wdata1;
    logic                  ack1;
    logic [data_width-1:0] rdata1;

    // Memory control pins and status
    logic                  mem_wr;
    logic                  mem_rd;
    logic [addr_width-1:0] mem_addr;
    logic                  busy;

    // Requester/memory side: issues requests, observes acks and memory pins.
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_wr, mem_rd, mem_addr, busy
    );

    // Arbiter side.
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, rdata0, ack1, rdata1,
        output mem_wr, mem_rd, mem_addr, busy
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way winner select.
// Build option MEM_ARB_RR_EN: defined -> round-robin on ties (the requester
// that was not granted last wins); undefined -> requester 0 always wins ties.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,         // {req1, req0}
    input  logic       last_grant,  // index granted most recently
    output logic       gnt_valid,
    output logic       gnt_idx
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority keeps last_grant in the port list but never consults it.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Winner select: a lone requester always wins; ties go by the build option.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = REQ_FETCH;
        if (req == 2'b10) begin
            gnt_idx = REQ_DATA;
        end else if (req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            gnt_idx = ~last_grant;
`else
            gnt_idx = REQ_FETCH;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port req/ack arbiter and sequencer for a single-port
// memory with a bidirectional data bus. Each access is IDLE -> ACCESS -> RESP,
// one access every three cycles. Tie-break policy is selected by the
// MEM_ARB_RR_EN build option inside rr_arbiter_2.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int addr_width = ADDR_WIDTH_DEF,
    parameter int data_width = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_arbiter_if.slave          bus,
    inout  wire  [data_width-1:0] mem_data
);

    arb_state_t            state_reg;
    arb_state_t            state_next;

    // Transaction latched at the IDLE sampling edge; requesters may change
    // their inputs once they see ack, so the access runs from these copies.
    logic                  we_reg;
    logic [addr_width-1:0] addr_reg;
    logic [data_width-1:0] wdata_reg;
    logic                  owner_reg;
    logic                  last_grant_reg;

    logic [data_width-1:0] rdata0_reg;
    logic [data_width-1:0] rdata1_reg;

    logic                  gnt_valid;
    logic                  gnt_idx;
    logic                  wr_en;
    logic                  rd_en;
    logic                  ack0_en;
    logic                  ack1_en;

    rr_arbiter_2 u_arb (
        .req        ({bus.req1, bus.req0}),
        .last_grant (last_grant_reg),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and strobes, decoded only from registered state so that
    // mem_wr/mem_rd are glitch-free and can never be high together.
    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        ack0_en    = 1'b0;
        ack1_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (gnt_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
                if (we_reg) begin
                    wr_en = 1'b1;
                end else begin
                    rd_en = 1'b1;
                end
            end
            RESP: begin
                // Requests are ignored here; a still-high req is a new
                // request sampled back in IDLE.
                state_next = IDLE;
                ack0_en    = (owner_reg == REQ_FETCH);
                ack1_en    = (owner_reg == REQ_DATA);
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the winner's request and remember it for round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            owner_reg      <= REQ_FETCH;
            last_grant_reg <= REQ_DATA;   // requester 0 wins the first tie
        end else if ((state_reg == IDLE) && gnt_valid) begin
            owner_reg      <= gnt_idx;
            last_grant_reg <= gnt_idx;
            if (gnt_idx == REQ_DATA) begin
                we_reg    <= bus.we1;
                addr_reg  <= bus.addr1;
                wdata_reg <= bus.wdata1;
            end else begin
                we_reg    <= bus.we0;
                addr_reg  <= bus.addr0;
                wdata_reg <= bus.wdata0;
            end
        end
    end

    // Capture read data into the owner's register at the edge ending ACCESS;
    // each rdata holds until that requester's next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_reg <= '0;
            rdata1_reg <= '0;
        end else if (rd_en) begin
            if (owner_reg == REQ_DATA) begin
                rdata1_reg <= mem_data;
            end else begin
                rdata0_reg <= mem_data;
            end
        end
    end

    // The arbiter drives the shared bus only during a write ACCESS.
    assign mem_data = wr_en ? wdata_reg : {data_width{1'bz}};

    assign bus.mem_wr   = wr_en;
    assign bus.mem_rd   = rd_en;
    assign bus.mem_addr = addr_reg;
    assign bus.ack0     = ack0_en;
    assign bus.ack1     = ack1_en;
    assign bus.rdata0   = rdata0_reg;
    assign bus.rdata1   = rdata1_reg;
    assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural
// single-port memory on the bidirectional bus. Expected grant order follows
// MEM_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    wire  [DW-1:0] mem_data;

    mem_arbiter_if #(.addr_width(AW), .data_width(DW)) bus ();

    mem_arbiter #(.addr_width(AW), .data_width(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural memory plus a backdoor write port for preloading.
    logic [DW-1:0] tb_mem [32];
    logic          bd_we   = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (bus.mem_wr) tb_mem[bus.mem_addr] <= mem_data;
        else if (bd_we) tb_mem[bd_addr] <= bd_data;
    end
    assign mem_data = bus.mem_rd ? tb_mem[bus.mem_addr] : {DW{1'bz}};

    // Handshake rule: a req may only fall while its ack is high.
    logic hs_check = 1'b0;
    logic req0_q   = 1'b0;
    logic req1_q   = 1'b0;
    always @(negedge clk) begin
        if (hs_check && rst_n) begin
            assert (!(req0_q && !bus.req0 && !bus.ack0)) else $error("handshake: req0 dropped before ack0");
            assert (!(req1_q && !bus.req1 && !bus.ack1)) else $error("handshake: req1 dropped before ack1");
        end
        req0_q <= bus.req0;
        req1_q <= bus.req1;
    end

    // Reference model: memory contents, last grant, per-requester rdata.
    logic [DW-1:0] model_mem [32];
    logic          model_last;
    logic [DW-1:0] model_rdata [2];

    // Expected per-cycle picture of one transaction pair (cycle 0 = drive).
    logic [7:0]    exp_wr, exp_rd, exp_ack0, exp_ack1;
    logic [AW-1:0] exp_addr [8];
    logic [DW-1:0] exp_data [8];

    // Observed per-cycle picture.
    logic [7:0]    obs_wr, obs_rd, obs_ack0, obs_ack1;
    logic [AW-1:0] obs_addr [8];
    logic [DW-1:0] obs_data [8];
    logic [DW-1:0] obs_rdata0 [8];
    logic [DW-1:0] obs_rdata1 [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we   = 1'b0;
        model_mem[a] = d;
    endtask

    // Transaction-level model: served requesters occupy consecutive 3-cycle
    // slots; slot k accesses memory in cycle 1+3k and acks in cycle 2+3k.
    task automatic model_pair(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic          ww [2];
        logic [AW-1:0] aa [2];
        logic [DW-1:0] dd [2];
        logic          ord [2];
        int n, r, acc;
        ww[0] = w0; aa[0] = a0; dd[0] = d0;
        ww[1] = w1; aa[1] = a1; dd[1] = d1;
        exp_wr = '0; exp_rd = '0; exp_ack0 = '0; exp_ack1 = '0;
        for (int c = 0; c < 8; c++) begin
            exp_addr[c] = '0;
            exp_data[c] = '0;
        end
        n = 0;
        ord[0] = REQ_FETCH;
        ord[1] = REQ_DATA;
        if (v0 && v1) begin
            ord[0] = RR ? ~model_last : REQ_FETCH;
            ord[1] = ~ord[0];
            n = 2;
        end else if (v0 || v1) begin
            ord[0] = v1;
            n = 1;
        end
        for (int k = 0; k < n; k++) begin
            r   = int'(ord[k]);
            acc = 1 + 3 * k;
            exp_addr[acc] = aa[r];
            if (ww[r]) begin
                exp_wr[acc]      = 1'b1;
                exp_data[acc]    = dd[r];
                model_mem[aa[r]] = dd[r];
            end else begin
                exp_rd[acc]    = 1'b1;
                exp_data[acc]  = model_mem[aa[r]];
                model_rdata[r] = model_mem[aa[r]];
            end
            if (r == 1) exp_ack1[acc + 1] = 1'b1;
            else        exp_ack0[acc + 1] = 1'b1;
            model_last = ord[k];
        end
    endtask

    // Drive one or two requests and record eight cycles of DUT behaviour;
    // each requester drops req as soon as it sees its ack.
    task automatic txn_pair(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.req0 = v0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = v1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            obs_wr[c]     = bus.mem_wr;
            obs_rd[c]     = bus.mem_rd;
            obs_ack0[c]   = bus.ack0;
            obs_ack1[c]   = bus.ack1;
            obs_addr[c]   = bus.mem_addr;
            obs_data[c]   = mem_data;
            obs_rdata0[c] = bus.rdata0;
            obs_rdata1[c] = bus.rdata1;
            if (bus.ack0) bus.req0 = 1'b0;
            if (bus.ack1) bus.req1 = 1'b0;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        $display("[TB] txn r0(v=%b we=%b a=%h d=%h) r1(v=%b we=%b a=%h d=%h) ack0=%b ack1=%b",
                 v0, w0, a0, d0, v1, w1, a1, d1, obs_ack0, obs_ack1);
    endtask

    task automatic test_reset();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({bus.ack0, bus.ack1, bus.mem_wr, bus.mem_rd, bus.busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got {ack0,ack1,wr,rd,busy}=%b want 00000",
                     {bus.ack0, bus.ack1, bus.mem_wr, bus.mem_rd, bus.busy});
        end
        n_tests++;
        if (bus.mem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 00", bus.mem_addr);
        end
        n_tests++;
        if (bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h want 00/00", bus.rdata0, bus.rdata1);
        end
        for (int i = 0; i < 32; i++) bd_write(AW'(i), DW'($urandom_range(0, 255)));
        model_last     = REQ_DATA;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        rst_n = 1'b1;
        tick();
        hs_check = 1'b1;
    endtask

    task automatic test_write_read();
        model_pair(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 5'h0A, 8'h5C);
        txn_pair  (1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 5'h0A, 8'h5C);
        n_tests++;
        if (obs_wr !== 8'b0000_0010 || obs_rd !== 8'b0) begin
            n_fail++;
            $display("FAIL wr_strobe: got wr=%b rd=%b want wr=00000010 rd=00000000", obs_wr, obs_rd);
        end
        n_tests++;
        if (obs_ack1 !== 8'b0000_0100 || obs_ack0 !== 8'b0) begin
            n_fail++;
            $display("FAIL wr_ack: got ack1=%b ack0=%b want 00000100/00000000", obs_ack1, obs_ack0);
        end
        n_tests++;
        if (obs_addr[1] !== 5'h0A || obs_data[1] !== 8'h5C) begin
            n_fail++;
            $display("FAIL wr_bus: got addr=%h data=%h want 0a/5c", obs_addr[1], obs_data[1]);
        end
        model_pair(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'h0A, 8'h00);
        txn_pair  (1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'h0A, 8'h00);
        n_tests++;
        if (obs_rd !== 8'b0000_0010 || obs_wr !== 8'b0 || obs_ack1 !== 8'b0000_0100) begin
            n_fail++;
            $display("FAIL rd_strobe: got rd=%b wr=%b ack1=%b want 00000010/00000000/00000100",
                     obs_rd, obs_wr, obs_ack1);
        end
        n_tests++;
        if (obs_rdata1[2] !== 8'h5C) begin
            n_fail++;
            $display("FAIL rd_data1: got %h want 5c", obs_rdata1[2]);
        end
    endtask

    task automatic test_read_fetch();
        bd_write(5'd3, 8'hA7);
        model_pair(1'b1, 1'b0, 5'd3, '0, 1'b0, 1'b0, '0, '0);
        txn_pair  (1'b1, 1'b0, 5'd3, '0, 1'b0, 1'b0, '0, '0);
        n_tests++;
        if (obs_ack0 !== 8'b0000_0100 || obs_ack1 !== 8'b0) begin
            n_fail++;
            $display("FAIL fetch_ack: got ack0=%b ack1=%b want 00000100/00000000", obs_ack0, obs_ack1);
        end
        n_tests++;
        if (obs_rdata0[2] !== 8'hA7) begin
            n_fail++;
            $display("FAIL fetch_data: got %h want a7", obs_rdata0[2]);
        end
    endtask

    task automatic test_random();
        logic          v0, v1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        int            pat;
        for (int it = 0; it < 24; it++) begin
            pat = int'($urandom_range(1, 3));
            v0 = pat[0];
            v1 = pat[1];
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            a0 = AW'($urandom_range(0, 7));   // narrow range forces same-address pairs
            a1 = AW'($urandom_range(0, 7));
            d0 = DW'($urandom_range(0, 255));
            d1 = DW'($urandom_range(0, 255));
            model_pair(v0, w0, a0, d0, v1, w1, a1, d1);
            txn_pair  (v0, w0, a0, d0, v1, w1, a1, d1);
            n_tests++;
            if (obs_wr !== exp_wr || obs_rd !== exp_rd) begin
                n_fail++;
                $display("FAIL rand_strobe it=%0d: got wr=%b rd=%b want wr=%b rd=%b", it, obs_wr, obs_rd, exp_wr, exp_rd);
            end
            n_tests++;
            if (obs_ack0 !== exp_ack0 || obs_ack1 !== exp_ack1) begin
                n_fail++;
                $display("FAIL rand_ack it=%0d: got ack0=%b ack1=%b want ack0=%b ack1=%b",
                         it, obs_ack0, obs_ack1, exp_ack0, exp_ack1);
            end
            n_tests++;
            if ((obs_wr & obs_rd) !== 8'b0) begin
                n_fail++;
                $display("FAIL rand_wr_rd_overlap it=%0d: got %b want 00000000", it, obs_wr & obs_rd);
            end
            for (int c = 0; c < 8; c++) begin
                if (exp_wr[c] || exp_rd[c]) begin
                    n_tests++;
                    if (obs_addr[c] !== exp_addr[c] || obs_data[c] !== exp_data[c]) begin
                        n_fail++;
                        $display("FAIL rand_bus it=%0d cyc=%0d: got addr=%h data=%h want addr=%h data=%h",
                                 it, c, obs_addr[c], obs_data[c], exp_addr[c], exp_data[c]);
                    end
                end
            end
            n_tests++;
            if (obs_rdata0[7] !== model_rdata[0] || obs_rdata1[7] !== model_rdata[1]) begin
                n_fail++;
                $display("FAIL rand_rdata it=%0d: got %h/%h want %h/%h",
                         it, obs_rdata0[7], obs_rdata1[7], model_rdata[0], model_rdata[1]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [15:0]   a0m, a1m, e0m, e1m;
        logic [AW-1:0] sa0, sa1;
        logic          w, both, rd_bad;
        hs_check = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_last     = REQ_DATA;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        sa0 = AW'($urandom_range(0, 31));
        sa1 = AW'($urandom_range(0, 31));
        e0m = '0; e1m = '0; a0m = '0; a1m = '0;
        for (int k = 0; k < 4; k++) begin
            w = RR ? ~model_last : REQ_FETCH;
            model_last = w;
            if (w) e1m[2 + 3 * k] = 1'b1;
            else   e0m[2 + 3 * k] = 1'b1;
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = sa0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = sa1;
        both = 1'b0;
        rd_bad = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) tick();
            a0m[c] = bus.ack0;
            a1m[c] = bus.ack1;
            if (bus.mem_rd && bus.mem_wr) both = 1'b1;
            if (bus.ack0 && bus.rdata0 !== model_mem[sa0]) rd_bad = 1'b1;
            if (bus.ack1 && bus.rdata1 !== model_mem[sa1]) rd_bad = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        $display("[TB] txn saturate a0=%h a1=%h ack0=%b ack1=%b", sa0, sa1, a0m, a1m);
        repeat (3) tick();
        n_tests++;
        if (a0m !== e0m || a1m !== e1m) begin
            n_fail++;
            $display("FAIL sat_order: got ack0=%b ack1=%b want ack0=%b ack1=%b", a0m, a1m, e0m, e1m);
        end
        n_tests++;
        if (both !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_wr_rd_overlap: got %b want 0", both);
        end
        n_tests++;
        if (rd_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_rdata: got bad=%b want 0", rd_bad);
        end
        if (e0m != 16'b0) model_rdata[0] = model_mem[sa0];
        if (e1m != 16'b0) model_rdata[1] = model_mem[sa1];
        hs_check = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        logic pulse;
        hs_check = 1'b0;
        bd_write(5'd7, 8'h11);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd7; bus.wdata0 = 8'hFF;
        tick();
        n_tests++;
        if (bus.mem_wr !== 1'b1 || mem_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL rst_pre_access: got wr=%b data=%h want 1/ff", bus.mem_wr, mem_data);
        end
        #2;
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        #1;
        n_tests++;
        if ({bus.mem_wr, bus.mem_rd, bus.ack0, bus.busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_async: got {wr,rd,ack0,busy}=%b want 0000", {bus.mem_wr, bus.mem_rd, bus.ack0, bus.busy});
        end
        pulse = 1'b0;
        repeat (3) begin
            tick();
            if (bus.ack0 || bus.mem_wr) pulse = 1'b1;
        end
        #2;
        rst_n = 1'b1;
        tick();
        if (bus.ack0 || bus.mem_wr) pulse = 1'b1;
        $display("[TB] txn reset during write a=07 d=ff mem[07]=%h", tb_mem[7]);
        n_tests++;
        if (pulse !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_quiet: got pulse=%b busy=%b want 0/0", pulse, bus.busy);
        end
        n_tests++;
        if (tb_mem[7] !== 8'h11) begin
            n_fail++;
            $display("FAIL rst_no_commit: got mem[7]=%h want 11", tb_mem[7]);
        end
        model_last     = REQ_DATA;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        hs_check = 1'b1;
        model_pair(1'b1, 1'b0, 5'd7, '0, 1'b0, 1'b0, '0, '0);
        txn_pair  (1'b1, 1'b0, 5'd7, '0, 1'b0, 1'b0, '0, '0);
        n_tests++;
        if (obs_ack0 !== 8'b0000_0100 || obs_rdata0[2] !== 8'h11) begin
            n_fail++;
            $display("FAIL rst_reread: got ack0=%b rdata0=%h want 00000100/11", obs_ack0, obs_rdata0[2]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_fetch();
        test_random();
        test_saturate();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
